// File: rtl/forward_pkg.sv
// Shared types and helpers for the forward_mac neuron engine:
// FSM state encoding, activation selectors and signed saturation.
package forward_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_ADDR,
        ST_DATA,
        ST_ACT,
        ST_SEND
    } state_t;

    localparam int ACT_LINEAR = 0;
    localparam int ACT_RELU   = 1;

    // Clamp a sign-extended value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/forward_act.sv
// Combinational activation stage: rescale the accumulator out of the
// fixed-point product domain, optionally apply ReLU, then saturate to W bits.
module forward_act
    import forward_pkg::*;
#(
    parameter int W    = 8,
    parameter int A    = 18,
    parameter int FRAC = 4,
    parameter int ACT  = 0
) (
    input  logic signed [A-1:0] acc,
    output logic        [W-1:0] r
);

    logic signed [A-1:0]  shifted;
    logic signed [63:0]   wide;
    logic signed [63:0]   act_val;

    always_comb begin
        shifted = acc >>> FRAC;
        wide    = {{(64 - A){shifted[A-1]}}, shifted};
        act_val = wide;
        if (ACT == ACT_RELU && wide < 0) begin
            act_val = '0;
        end
        r = W'(sat_w(act_val, W));
    end

endmodule

// File: rtl/forward_mac.sv
// Single-neuron forward pass: gathers N samples, streams N weights plus a bias
// from external memory through a sequential MAC, activates and broadcasts to M sinks.
module forward_mac
    import forward_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 2,
    parameter int M    = 2,
    parameter int FRAC = 4,
    parameter int ACT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             s_i_stb,
    input  logic [N*W-1:0]           s_i_dat,
    output logic [N-1:0]             s_i_rdy,
    input  logic                     m_a_rdy,
    output logic                     m_a_stb,
    output logic [$clog2(N+1)-1:0]   m_a_dat,
    input  logic                     s_d_stb,
    input  logic [W-1:0]             s_d_dat,
    output logic                     s_d_rdy,
    input  logic [M-1:0]             m_o_rdy,
    output logic [M-1:0]             m_o_stb,
    output logic [M*W-1:0]           m_o_dat
);

    localparam int KW = $clog2(N + 1);
    localparam int A  = 2 * W + KW;

    state_t                 state;
    state_t                 state_next;
    logic [N-1:0]           full;
    logic [W-1:0]           slot [N];
    logic [KW-1:0]          k;
    logic signed [A-1:0]    acc;
    logic [W-1:0]           result;
    logic [W-1:0]           act_r;
    logic [M-1:0]           o_stb;
    logic [N-1:0]           accept;
    logic                   last_term;
    logic                   data_fire;
    logic                   mask_clear;
    logic                   start;
    logic signed [W-1:0]    xk;
    logic signed [2*W-1:0]  term;

    assign s_i_rdy    = ~full;
    assign accept     = s_i_stb & ~full;
    assign m_a_stb    = (state == ST_ADDR);
    assign m_a_dat    = k;
    assign s_d_rdy    = (state == ST_DATA);
    assign m_o_stb    = o_stb;
    assign m_o_dat    = {M{result}};
    assign last_term  = (k == KW'(N));
    assign data_fire  = (state == ST_DATA) && s_d_stb;
    assign mask_clear = data_fire && last_term;

    // A sample landing in the cycle the mask clears belongs to the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= (mask_clear ? '0 : full) | accept;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
                slot[i] <= s_i_dat[i*W +: W];
            end
        end
    end

    // The bias term uses x = 2**FRAC, i.e. the bias shifted into product scale.
    always_comb begin
        xk = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                xk = slot[i];
            end
        end
        if (last_term) begin
            term = (2*W)'($signed(s_d_dat)) <<< FRAC;
        end else begin
            term = (2*W)'(xk) * (2*W)'($signed(s_d_dat));
        end
    end

    forward_act #(
        .W    (W),
        .A    (A),
        .FRAC (FRAC),
        .ACT  (ACT)
    ) u_act (
        .acc (acc),
        .r   (act_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_COLLECT: if (&full) state_next = ST_ADDR;
            ST_ADDR:    if (m_a_rdy) state_next = ST_DATA;
            ST_DATA:    if (s_d_stb) state_next = last_term ? ST_ACT : ST_ADDR;
            ST_ACT:     state_next = ST_SEND;
            ST_SEND: begin
                if ((o_stb & ~m_o_rdy) == '0) begin
                    state_next = (&full) ? ST_ADDR : ST_COLLECT;
                end
            end
            default:    state_next = ST_COLLECT;
        endcase
        start = (state_next == ST_ADDR) && (state == ST_COLLECT || state == ST_SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            k      <= '0;
            result <= '0;
            o_stb  <= '0;
        end else begin
            if (start) begin
                acc <= '0;
                k   <= '0;
            end else if (data_fire) begin
                acc <= acc + A'(term);
                if (!last_term) begin
                    k <= k + KW'(1);
                end
            end
            if (state == ST_ACT) begin
                result <= act_r;
                o_stb  <= '1;
            end else if (state == ST_SEND) begin
                o_stb <= o_stb & ~m_o_rdy;
            end
        end
    end

endmodule

// File: tb/tb_forward_mac.sv
// Self-checking bench for forward_mac: a linear and a ReLU instance run in
// lockstep from shared stimulus and are compared against an arithmetic reference.
module tb_forward_mac;

    localparam int W    = 8;
    localparam int N    = 2;
    localparam int M    = 2;
    localparam int FRAC = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     s_i_stb;
    logic [N*W-1:0]   s_i_dat;
    logic [N-1:0]     s_i_rdy, s_i_rdy_r;
    logic             m_a_rdy = 1'b0;
    logic             m_a_stb, m_a_stb_r;
    logic [1:0]       m_a_dat, m_a_dat_r;
    logic             s_d_stb = 1'b0;
    logic [W-1:0]     s_d_dat = '0;
    logic             s_d_rdy, s_d_rdy_r;
    logic [M-1:0]     m_o_rdy = '0;
    logic [M-1:0]     m_o_stb, m_o_stb_r;
    logic [M*W-1:0]   m_o_dat, m_o_dat_r;

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               last_in_cyc = 0;
    int               rise0_cyc = 0;
    bit               prev_o0 = 1'b0;
    bit               lockstep_ok = 1'b1;
    bit               mem_stall = 1'b0;
    bit               out_rand = 1'b0;
    bit               have_pend = 1'b0;
    logic [1:0]       pend_addr = '0;
    logic [M-1:0]     rdy_force = '1;
    logic [W-1:0]     wmem [N+1];
    logic [W-1:0]     q_lin0[$], q_lin1[$], q_relu0[$], q_relu1[$];
    logic [1:0]       addr_log[$];

    always #5 clk = ~clk;

    forward_mac #(.W(W), .N(N), .M(M), .FRAC(FRAC), .ACT(0)) u_lin (
        .clk(clk), .rst_n(rst_n),
        .s_i_stb(s_i_stb), .s_i_dat(s_i_dat), .s_i_rdy(s_i_rdy),
        .m_a_rdy(m_a_rdy), .m_a_stb(m_a_stb), .m_a_dat(m_a_dat),
        .s_d_stb(s_d_stb), .s_d_dat(s_d_dat), .s_d_rdy(s_d_rdy),
        .m_o_rdy(m_o_rdy), .m_o_stb(m_o_stb), .m_o_dat(m_o_dat)
    );

    forward_mac #(.W(W), .N(N), .M(M), .FRAC(FRAC), .ACT(1)) u_relu (
        .clk(clk), .rst_n(rst_n),
        .s_i_stb(s_i_stb), .s_i_dat(s_i_dat), .s_i_rdy(s_i_rdy_r),
        .m_a_rdy(m_a_rdy), .m_a_stb(m_a_stb_r), .m_a_dat(m_a_dat_r),
        .s_d_stb(s_d_stb), .s_d_dat(s_d_dat), .s_d_rdy(s_d_rdy_r),
        .m_o_rdy(m_o_rdy), .m_o_stb(m_o_stb_r), .m_o_dat(m_o_dat_r)
    );

    // Observe handshakes on the active edge and log addresses, inputs and results.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_o0 <= m_o_stb[0];
        if (!rst_n) begin
            have_pend <= 1'b0;
        end else begin
            if (m_a_stb && m_a_rdy) begin
                addr_log.push_back(m_a_dat);
                pend_addr <= m_a_dat;
                have_pend <= 1'b1;
            end else if (s_d_stb && s_d_rdy) begin
                have_pend <= 1'b0;
            end
            if ((s_i_stb & s_i_rdy) != '0) last_in_cyc <= cyc;
            if (m_o_stb[0] && !prev_o0) rise0_cyc <= cyc;
            if (m_o_stb[0] && m_o_rdy[0]) q_lin0.push_back(m_o_dat[0 +: W]);
            if (m_o_stb[1] && m_o_rdy[1]) q_lin1.push_back(m_o_dat[W +: W]);
            if (m_o_stb_r[0] && m_o_rdy[0]) q_relu0.push_back(m_o_dat_r[0 +: W]);
            if (m_o_stb_r[1] && m_o_rdy[1]) q_relu1.push_back(m_o_dat_r[W +: W]);
            if ({s_i_rdy, m_a_stb, m_a_dat, s_d_rdy, m_o_stb} !==
                {s_i_rdy_r, m_a_stb_r, m_a_dat_r, s_d_rdy_r, m_o_stb_r}) lockstep_ok <= 1'b0;
        end
    end

    // Weight memory and output sinks, driven mid-cycle with optional random stalls.
    always @(negedge clk) begin
        m_o_rdy = out_rand ? M'($urandom) : rdy_force;
        if (!rst_n) begin
            m_a_rdy = 1'b0;
            s_d_stb = 1'b0;
        end else begin
            m_a_rdy = mem_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (have_pend) begin
                if (!s_d_stb) s_d_stb = mem_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_d_dat = wmem[pend_addr];
            end else begin
                s_d_stb = 1'b0;
            end
        end
    end

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: exact dot product plus scaled bias, floor-rescale, activate, clamp.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] x0, x1, w0, w1, b, input bit relu);
        longint sum;
        longint r;
        sum = sx(x0) * sx(w0) + sx(x1) * sx(w1) + sx(b) * (longint'(1) << FRAC);
        r = sum >>> FRAC;
        if (relu && r < 0) r = 0;
        if (r > (longint'(1) << (W - 1)) - 1) r = (longint'(1) << (W - 1)) - 1;
        else if (r < -(longint'(1) << (W - 1))) r = -(longint'(1) << (W - 1));
        return r[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ch, input logic [W-1:0] v);
        int n = 0;
        @(negedge clk);
        s_i_stb[ch] = 1'b1;
        s_i_dat[ch*W +: W] = v;
        while (!s_i_rdy[ch] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("put_ready", 32'(s_i_rdy[ch]), 32'd1);
        @(negedge clk);
        s_i_stb[ch] = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] e_lin, input logic [W-1:0] e_relu);
        int n = 0;
        while ((q_lin0.size() == 0 || q_lin1.size() == 0 || q_relu0.size() == 0 ||
                q_relu1.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrive"}, 32'(n < 2000), 32'd1);
        if (n < 2000) begin
            check({tag, "_lin0"}, 32'(q_lin0.pop_front()), 32'(e_lin));
            check({tag, "_lin1"}, 32'(q_lin1.pop_front()), 32'(e_lin));
            check({tag, "_relu0"}, 32'(q_relu0.pop_front()), 32'(e_relu));
            check({tag, "_relu1"}, 32'(q_relu1.pop_front()), 32'(e_relu));
        end
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] x0, x1, w0, w1, b, input bit x1_first);
        wmem[0] = w0;
        wmem[1] = w1;
        wmem[2] = b;
        if (x1_first) begin
            put(1, x1);
            put(0, x0);
        end else begin
            put(0, x0);
            put(1, x1);
        end
        wait_result(tag, ref_out(x0, x1, w0, w1, b, 1'b0), ref_out(x0, x1, w0, w1, b, 1'b1));
    endtask

    initial begin
        logic [W-1:0] a, b, c, d, r0, r1, r2;
        logic [W-1:0] hold_exp;
        int n;
        s_i_stb = '0;
        s_i_dat = '0;
        for (int i = 0; i <= N; i++) wmem[i] = '0;
        $display("[TB] start");

        repeat (3) @(negedge clk);
        check("rst_o_stb", 32'(m_o_stb), 32'd0);
        check("rst_a_stb", 32'(m_a_stb), 32'd0);
        check("rst_d_rdy", 32'(s_d_rdy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_i_rdy", 32'(s_i_rdy), 32'h3);

        addr_log.delete();
        run_vec("zero", 8'h10, 8'h20, 8'h18, 8'hF0, 8'h08, 1'b0);
        check("latency", 32'(rise0_cyc - last_in_cyc - 1), 32'd8);
        check("addr_count", 32'(addr_log.size()), 32'd3);
        for (int i = 0; i < addr_log.size(); i++) check("addr_order", 32'(addr_log[i]), 32'(i));

        run_vec("plain", 8'h10, 8'h10, 8'h20, 8'h20, 8'h00, 1'b0);
        run_vec("sat_hi", 8'h70, 8'h70, 8'h70, 8'h70, 8'h00, 1'b0);
        run_vec("sat_lo", 8'h70, 8'h70, 8'h90, 8'h90, 8'h00, 1'b0);
        run_vec("neg", 8'h10, 8'h00, 8'hF0, 8'h00, 8'h00, 1'b1);

        // Early second sample on channel 1 must wait and then join the next vector.
        $display("[TB] repeated channel sample");
        a = 8'h11; b = 8'h23; c = 8'h35; d = 8'hE7;
        wmem[0] = 8'h19; wmem[1] = 8'hD3; wmem[2] = 8'h05;
        put(1, a);
        s_i_stb[1] = 1'b1;
        s_i_dat[W +: W] = b;
        put(0, c);
        check("x1_blocked", 32'(s_i_rdy[1]), 32'd0);
        n = 0;
        while (!s_i_rdy[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("x1_freed", 32'(s_i_rdy[1]), 32'd1);
        @(negedge clk);
        s_i_stb[1] = 1'b0;
        wait_result("dupA", ref_out(c, a, 8'h19, 8'hD3, 8'h05, 1'b0), ref_out(c, a, 8'h19, 8'hD3, 8'h05, 1'b1));
        put(0, d);
        wait_result("dupB", ref_out(d, b, 8'h19, 8'hD3, 8'h05, 1'b0), ref_out(d, b, 8'h19, 8'hD3, 8'h05, 1'b1));

        // Output 1 held off while the next vector is collected.
        $display("[TB] output back-pressure");
        rdy_force = 2'b01;
        wmem[0] = 8'h20; wmem[1] = 8'h30; wmem[2] = 8'hFC;
        hold_exp = ref_out(8'h12, 8'h0A, 8'h20, 8'h30, 8'hFC, 1'b0);
        put(0, 8'h12);
        put(1, 8'h0A);
        n = 0;
        while (q_lin0.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("hold_out0_arrive", 32'(q_lin0.size()), 32'd1);
        if (q_lin0.size() > 0) check("hold_out0", 32'(q_lin0[0]), 32'(hold_exp));
        wmem[0] = 8'hE0; wmem[1] = 8'h08; wmem[2] = 8'h10;
        put(1, 8'h21);
        put(0, 8'h33);
        repeat (6) @(negedge clk);
        check("hold_stb1", 32'(m_o_stb[1]), 32'd1);
        check("hold_dat1", 32'(m_o_dat[W +: W]), 32'(hold_exp));
        check("hold_collected", 32'(s_i_rdy), 32'd0);
        rdy_force = 2'b11;
        n = 0;
        while (m_o_stb[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("addr_after_hs", 32'(m_a_stb), 32'd1);
        wait_result("holdA", hold_exp, ref_out(8'h12, 8'h0A, 8'h20, 8'h30, 8'hFC, 1'b1));
        wait_result("holdB", ref_out(8'h33, 8'h21, 8'hE0, 8'h08, 8'h10, 1'b0),
                    ref_out(8'h33, 8'h21, 8'hE0, 8'h08, 8'h10, 1'b1));

        mem_stall = 1'b1;
        run_vec("stall_plain", 8'h10, 8'h10, 8'h20, 8'h20, 8'h00, 1'b0);
        run_vec("stall_sat", 8'h70, 8'h70, 8'h90, 8'h90, 8'h00, 1'b1);
        mem_stall = 1'b0;

        // Reset in the middle of the k=1 weight fetch discards the vector.
        $display("[TB] reset during fetch");
        wmem[0] = 8'h7F; wmem[1] = 8'h7F; wmem[2] = 8'h7F;
        put(0, 8'h55);
        put(1, 8'h66);
        n = 0;
        while (!(s_d_rdy && m_a_dat == 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_k1", 32'(s_d_rdy && m_a_dat == 2'd1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_a_stb", 32'(m_a_stb), 32'd0);
        check("rst_mid_d_rdy", 32'(s_d_rdy), 32'd0);
        check("rst_mid_o_stb", 32'(m_o_stb), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_i_rdy", 32'(s_i_rdy), 32'h3);
        check("rst_no_result", 32'(q_lin0.size()), 32'd0);
        run_vec("post_rst", 8'h08, 8'h18, 8'h40, 8'hC8, 8'h02, 1'b1);

        $display("[TB] random vectors");
        for (int t = 0; t < 25; t++) begin
            mem_stall = 1'($urandom_range(0, 1));
            out_rand  = 1'($urandom_range(0, 1));
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            run_vec("rand", r0, r1, 8'($urandom), r2, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        out_rand = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("lockstep", 32'(lockstep_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
